// File: rtl/plru_replacement_unit.sv
// Tree pseudo-LRU victim selection for an N-way set-associative cache.
// Each set keeps NUM_WAYS-1 heap-ordered tree bits. A sequenced flush clears the sets one per cycle.
module plru_replacement_unit #(
    parameter int NUM_SETS = 16,
    parameter int NUM_WAYS = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [$clog2(NUM_SETS)-1:0] set,
    input  logic                        cru_enable,
    input  logic                        access_valid,
    input  logic [$clog2(NUM_WAYS)-1:0] access_way,
    input  logic                        flush,
    output logic [$clog2(NUM_WAYS)-1:0] replace_way,
    output logic                        victim_valid,
    output logic                        busy
);
    localparam int SetSize = $clog2(NUM_SETS);
    localparam int WaySize = $clog2(NUM_WAYS);

    typedef enum logic {IDLE, FLUSH} state_e;

    state_e                               state_q, state_d;
    logic [SetSize-1:0]                   cnt_q, cnt_d;
    logic [NUM_SETS-1:0][NUM_WAYS-2:0]    tree_q, tree_d;
    logic [NUM_WAYS-2:0]                  row;
    logic [WaySize-1:0]                   walk;
    int                                   node;

    assign busy = (state_q == FLUSH);

    // Heap walk: bit 0 goes to child 2n+1, bit 1 to child 2n+2.
    always_comb begin
        row  = tree_q[set];
        walk = '0;
        node = 0;
        for (int l = 0; l < WaySize; l++) begin
            walk[WaySize-1-l] = row[node];
            node = 2 * node + 1 + int'(row[node]);
        end
    end

    assign replace_way  = busy ? '0 : walk;
    assign victim_valid = cru_enable & ~busy & rst_n;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
            FLUSH: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SetSize'(NUM_SETS - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The node at level l on the path to a way sits at (2^l - 1) plus the way's top l bits.
    always_comb begin
        tree_d = tree_q;
        if (state_q == FLUSH) begin
            tree_d[cnt_q] = '0;
        end else if (access_valid) begin
            for (int l = 0; l < WaySize; l++) begin
                tree_d[set][(1 << l) - 1 + (int'(access_way) >> (WaySize - l))] =
                    ~access_way[WaySize-1-l];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tree_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tree_q  <= tree_d;
        end
    end
endmodule

// File: tb/tb_plru_replacement_unit.sv
// Scoreboard bench for plru_replacement_unit: the driver pushes expected outputs from a
// level/prefix direction model; a negedge monitor pops them and compares.
module tb_plru_replacement_unit;
    localparam int NS = 16;
    localparam int NW = 4;
    localparam int SS = $clog2(NS);
    localparam int WS = $clog2(NW);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [SS-1:0] set = '0;
    logic          cru_enable = 1'b0;
    logic          access_valid = 1'b0;
    logic [WS-1:0] access_way = '0;
    logic          flush = 1'b0;
    logic [WS-1:0] replace_way;
    logic          victim_valid;
    logic          busy;

    plru_replacement_unit #(.NUM_SETS(NS), .NUM_WAYS(NW)) dut (
        .clk(clk), .rst_n(rst_n), .set(set), .cru_enable(cru_enable),
        .access_valid(access_valid), .access_way(access_way), .flush(flush),
        .replace_way(replace_way), .victim_valid(victim_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int way;
        bit vv;
        bit bsy;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   fails = 0;

    // dir[s][l][p]: at depth l, under path prefix p, 1 means the victim is in the upper half.
    bit   dir[NS][WS][NW];
    int   flush_left = 0;

    function automatic int m_victim(int s);
        int p = 0;
        for (int l = 0; l < WS; l++) p = p * 2 + int'(dir[s][l][p]);
        return p;
    endfunction

    function automatic void m_touch(int s, int w);
        for (int l = 0; l < WS; l++) begin
            int p = w >> (WS - l);
            dir[s][l][p] = (((w >> (WS - 1 - l)) & 1) == 1) ? 1'b0 : 1'b1;
        end
    endfunction

    function automatic void m_clear(int s);
        for (int l = 0; l < WS; l++)
            for (int p = 0; p < NW; p++) dir[s][l][p] = 1'b0;
    endfunction

    task automatic step(input bit rn, input int s, input bit ce, input bit av,
                        input int aw, input bit fl);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n        = rn;
        set          = SS'(s);
        cru_enable   = ce;
        access_valid = av;
        access_way   = WS'(aw);
        flush        = fl;
        if (!rn) begin
            for (int i = 0; i < NS; i++) m_clear(i);
            flush_left = 0;
            e = '{way: 0, vv: 1'b0, bsy: 1'b0};
            q.push_back(e);
        end else begin
            e.bsy = (flush_left > 0);
            e.vv  = ce && !e.bsy;
            e.way = e.bsy ? 0 : m_victim(s);
            q.push_back(e);
            if (e.bsy) begin
                m_clear(NS - flush_left);
                flush_left--;
            end else begin
                if (av) m_touch(s, aw);
                if (fl) flush_left = NS;
            end
        end
    endtask

    // Monitor: compare outputs against queued expectations and measure busy pulse length.
    initial begin
        exp_t e;
        int   run = 0;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (int'(replace_way) != e.way || victim_valid != e.vv || busy != e.bsy) begin
                    fails++;
                    $display("FAIL outputs t=%0t set=%0d: got way=%0d vv=%0b busy=%0b, expected way=%0d vv=%0b busy=%0b",
                             $time, set, replace_way, victim_valid, busy, e.way, e.vv, e.bsy);
                end
            end
            if (!rst_n) run = 0;
            else if (busy) run++;
            else if (run > 0) begin
                checks++;
                if (run != NS) begin
                    fails++;
                    $display("FAIL busy_len: got %0d cycles, expected %0d", run, NS);
                end
                run = 0;
            end
        end
    end

    initial begin
        int v;
        step(1'b0, 0, 1'b1, 1'b0, 0, 1'b0);
        step(1'b0, 3, 1'b1, 1'b0, 0, 1'b0);
        // Fresh tree after reset: set 3 victim 0, valid.
        step(1'b1, 3, 1'b1, 1'b0, 0, 1'b0);
        // Set 5: chase the victim, expecting 0,2,1,3,0.
        for (int i = 0; i < 5; i++) begin
            v = m_victim(5);
            step(1'b1, 5, 1'b1, 1'b1, v, 1'b0);
        end
        step(1'b1, 5, 1'b1, 1'b0, 0, 1'b0);
        // Sets 1 and 2 touched back to back; set 0 untouched.
        step(1'b1, 1, 1'b0, 1'b1, 3, 1'b0);
        step(1'b1, 2, 1'b0, 1'b1, 0, 1'b0);
        step(1'b1, 1, 1'b1, 1'b0, 0, 1'b0);
        step(1'b1, 2, 1'b1, 1'b0, 0, 1'b0);
        step(1'b1, 0, 1'b1, 1'b0, 0, 1'b0);
        // Same-cycle read and update on a fresh set: pre-update victim, then 2.
        step(1'b1, 7, 1'b1, 1'b1, 0, 1'b0);
        step(1'b1, 7, 1'b1, 1'b0, 0, 1'b0);
        // Dirty more sets, then flush with an access landing mid-flush.
        step(1'b1, 9, 1'b0, 1'b1, 1, 1'b0);
        step(1'b1, 15, 1'b0, 1'b1, 2, 1'b0);
        step(1'b1, 4, 1'b1, 1'b1, 0, 1'b1);
        for (int i = 0; i < NS; i++)
            step(1'b1, i, 1'b1, (i == 6), 3, (i == 10));
        for (int i = 0; i < NS; i++) step(1'b1, i, 1'b1, 1'b0, 0, 1'b0);
        // Reset dropped in the 8th flush cycle, then a new flush after release.
        step(1'b1, 5, 1'b1, 1'b1, 3, 1'b0);
        step(1'b1, 12, 1'b1, 1'b1, 1, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, i, 1'b1, 1'b0, 0, 1'b0);
        step(1'b0, 5, 1'b1, 1'b0, 0, 1'b0);
        step(1'b1, 12, 1'b1, 1'b0, 0, 1'b0);
        for (int i = 0; i < NS; i++) step(1'b1, i, 1'b1, 1'b0, 0, 1'b0);
        step(1'b1, 3, 1'b0, 1'b1, 2, 1'b1);
        for (int i = 0; i < NS + 2; i++) step(1'b1, 3, 1'b1, 1'b0, 0, 1'b0);
        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 600; i++)
            step(1'b1, int'($urandom_range(NS - 1)), 1'($urandom_range(1)),
                 1'($urandom_range(1)), int'($urandom_range(NW - 1)),
                 ($urandom_range(49) == 0));
        for (int i = 0; i < NS + 2; i++) step(1'b1, i % NS, 1'b1, 1'b0, 0, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/plru_replacement_unit.md
Name: plru_replacement_unit

Overview:
Tree pseudo-LRU replacement unit for the N-way set-associative data cache. It sits beside the cache controller and consumes its set index, its `cru_enable` and the access outcome. It produces the victim way that the controller uses as `replace_way` when every way of a set is valid. It also supports a sequenced flush that returns every set's tree to the reset state.

Parameters:
- NUM_SETS, 16, number of cache sets; power of two, ≥2.
- NUM_WAYS, 4, associativity; power of two, ≥2; each set holds NUM_WAYS-1 tree bits.
- SetSize (localparam), $clog2(NUM_SETS).
- WaySize (localparam), $clog2(NUM_WAYS).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- set  input  SetSize  set index of the current access, from the controller.
- cru_enable  input  1  controller needs a victim for `set` this cycle.
- access_valid  input  1  a way of `set` was touched this cycle (hit or fill).
- access_way  input  WaySize  way touched when access_valid=1.
- flush  input  1  pulse; starts a clear of all trees.
- replace_way  output  WaySize  victim way for `set`.
- victim_valid  output  1  replace_way is meaningful (cru_enable=1 and not busy).
- busy  output  1  flush in progress.

Behaviour:
- Reset is asynchronous and active-low: clock `clk`, reset `rst_n`. While rst_n=0:
  - all tree bits = 0;
  - FSM in IDLE, flush counter = 0;
  - busy = 0, victim_valid = 0, replace_way = 0.
- Storage: tree[NUM_SETS][NUM_WAYS-1] flops, heap-indexed. Node 0 is the root; node k has children 2k+1 and 2k+2. Leaves map to ways in ascending order, left to right.
- Bit semantics: 0 = the victim lies in the lower-index (left) subtree; 1 = the victim lies in the upper (right) subtree.
- Victim read is combinational with 0-cycle latency:
  - Walk the tree of `set` from the root, following each bit; the leaf reached is replace_way.
  - When not busy, replace_way is the walked leaf regardless of cru_enable.
  - victim_valid = cru_enable & ~busy.
- Update happens at the clock edge, visible the next cycle:
  - Condition: access_valid=1 and ~busy.
  - For every node on the path to access_way, the bit is set to point away from that way: left-subtree access writes 1, right-subtree access writes 0.
  - Nodes off the path are unchanged. Only the addressed set is written.
- Simultaneous cru_enable and access_valid on the same set: replace_way reflects the pre-update tree; the update still commits at the edge.
- access_way width equals WaySize. No out-of-range value exists for power-of-two NUM_WAYS.
- FSM states are IDLE and FLUSH.
  - IDLE, flush=1: go to FLUSH, counter = 0, busy = 1 from the next cycle.
  - FLUSH: each cycle clears tree[counter] to 0 and increments the counter.
  - FLUSH, counter = NUM_SETS-1: clear that set and return to IDLE. busy falls the following cycle.
  - Flush therefore lasts exactly NUM_SETS cycles with busy=1.
- While busy:
  - access_valid is ignored (no update);
  - replace_way = 0 and victim_valid = 0;
  - flush is ignored; there is no restart.
- flush and access_valid in the same IDLE cycle: the access update commits first, then FLUSH clears that set anyway.
- Reset asserted mid-flush: immediate return to IDLE, all bits 0, busy = 0.
- No data or tag storage; the block never stalls the controller outside flush.

Test Plan:
- Post-reset, NUM_WAYS=4, set=3, cru_enable=1 → replace_way=0, victim_valid=1.
- Set 5 from reset, each cycle access the current victim (access_valid=1, access_way=replace_way) → victims 0,2,1,3,0.
  - Tree bits after the first access are {root=1, n1=1, n2=0}.
- Access way 3 of set 1 and way 0 of set 2 in consecutive cycles → set 1 victim=0, set 2 victim=2, set 0 victim=0 (untouched).
- Same-cycle cru_enable + access_valid, set 7, access_way=0, fresh tree → replace_way=0 that cycle and 2 the next.
- Dirty several sets, pulse flush:
  - busy=1 for exactly 16 cycles, victim_valid=0 throughout;
  - an access_valid issued mid-flush has no effect;
  - afterwards every set's victim=0.
- Drop rst_n during cycle 8 of a flush → busy=0 immediately, all victims 0, a new flush is accepted after release.
